// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM encoding, the PC-update select and the default halt/NOP words.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PcHold = 2'd0,
    PcInc  = 2'd1,
    PcLoad = 2'd2
  } pc_mode_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle between instruction memory / pipeline control and the fetch unit.
// The fetch unit is the slave; memory and pipeline control act as the master.
interface instruction_fetch_unit_if;

  logic [31:0] Instruction;
  logic        Stall;
  logic        Flush;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] PCResult;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        Halted;
  logic [31:0] FetchCount;

  modport master (
    output Instruction, Stall, Flush, Redirect, RedirectTarget,
    input  PCResult, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, Halted, FetchCount
  );

  modport slave (
    input  Instruction, Stall, Flush, Redirect, RedirectTarget,
    output PCResult, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, Halted, FetchCount
  );

endinterface

// File: rtl/program_counter.sv
// PC register with its next-PC mux (hold / +4 / word-aligned redirect load).
// The PC output comes straight from the flop so the memory address path has no logic.
module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_mode_e    mode,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    unique case (mode)
      PcHold:  pc_d = pc_q;
      PcInc:   pc_d = pc_q + 32'd4;
      PcLoad:  pc_d = {target[31:2], 2'b00};
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALTED control, IF/ID pipeline register and fetch counter.
// Priority of controls is Redirect > Flush > Stall > halt detection > normal fetch.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input logic                     Clk,
  input logic                     Reset,
  instruction_fetch_unit_if.slave bus
);

  fetch_state_e state_q, state_d;
  pc_mode_e     pc_mode;
  logic         ifid_load;
  logic         ifid_clear;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         is_halt;

  logic [31:0]  ifid_instr_q;
  logic [31:0]  ifid_pc4_q;
  logic         ifid_valid_q;
  logic [31:0]  fetch_count_q;

  assign pc_plus4 = pc + 32'd4;
  assign is_halt  = (bus.Instruction == HALT_WORD);

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .clk    (Clk),
    .rst_n  (Reset),
    .mode   (pc_mode),
    .target (bus.RedirectTarget),
    .pc     (pc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!bus.Redirect && !bus.Flush && !bus.Stall && is_halt) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (bus.Redirect) begin
          state_d = StRun;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_mode    = PcHold;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    unique case (state_q)
      StBoot: ;
      StRun: begin
        if (bus.Redirect) begin
          pc_mode    = PcLoad;
          ifid_clear = 1'b1;
        end else if (bus.Flush) begin
          pc_mode    = bus.Stall ? PcHold : PcInc;
          ifid_clear = 1'b1;
        end else if (bus.Stall) begin
          pc_mode = PcHold;
        end else if (is_halt) begin
          ifid_clear = 1'b1;
        end else begin
          pc_mode   = PcInc;
          ifid_load = 1'b1;
        end
      end
      StHalted: begin
        // Stall and Flush are ignored here; only a redirect restarts fetch.
        ifid_clear = 1'b1;
        if (bus.Redirect) begin
          pc_mode = PcLoad;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ifid_instr_q  <= NOP_WORD;
      ifid_pc4_q    <= 32'h0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'h0;
    end else if (ifid_load) begin
      ifid_instr_q  <= bus.Instruction;
      ifid_pc4_q    <= pc_plus4;
      ifid_valid_q  <= 1'b1;
      if (fetch_count_q != 32'hFFFF_FFFF) begin
        fetch_count_q <= fetch_count_q + 32'd1;
      end
    end else if (ifid_clear) begin
      ifid_instr_q <= NOP_WORD;
      ifid_valid_q <= 1'b0;
    end
  end

  assign bus.PCResult          = pc;
  assign bus.IF_ID_Instruction = ifid_instr_q;
  assign bus.IF_ID_PCPlus4     = ifid_pc4_q;
  assign bus.IF_ID_Valid       = ifid_valid_q;
  assign bus.Halted            = (state_q == StHalted);
  assign bus.FetchCount        = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a vector table for the main flow plus
// hand-written sequences for the halted state, reset-PC wrap and asynchronous reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  logic [31:0] mem [64];
  int unsigned checks;
  int unsigned errors;

  instruction_fetch_unit_if bus0 ();
  instruction_fetch_unit_if bus1 ();

  assign bus0.Instruction = mem[bus0.PCResult[7:2]];
  assign bus1.Instruction = mem[bus1.PCResult[7:2]];

  instruction_fetch_unit dut0 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus0)
  );

  instruction_fetch_unit #(
    .RESET_PC (32'hFFFF_FFF8)
  ) dut1 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        valid;
    logic        halted;
    logic [31:0] count;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic s, logic f, logic r, logic [31:0] t, logic [31:0] pc,
                              logic [31:0] ins, logic [31:0] p4, logic v, logic h,
                              logic [31:0] c);
    vec_t x;
    x.stall = s; x.flush = f; x.redirect = r; x.target = t;
    x.pc = pc; x.instr = ins; x.p4 = p4; x.valid = v; x.halted = h; x.count = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic s, input logic f, input logic r, input logic [31:0] t);
    bus0.Stall = s;
    bus0.Flush = f;
    bus0.Redirect = r;
    bus0.RedirectTarget = t;
  endtask

  task automatic chk_all0(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] p4, input logic v, input logic h,
                          input logic [31:0] c);
    chk({tag, ".pc"}, bus0.PCResult, pc);
    chk({tag, ".instr"}, bus0.IF_ID_Instruction, ins);
    chk({tag, ".pc4"}, bus0.IF_ID_PCPlus4, p4);
    chk({tag, ".valid"}, {31'd0, bus0.IF_ID_Valid}, {31'd0, v});
    chk({tag, ".halted"}, {31'd0, bus0.Halted}, {31'd0, h});
    chk({tag, ".count"}, bus0.FetchCount, c);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[4] = HALT;
    mem[62] = 32'hAA; mem[63] = 32'hBB;

    //           stall flush redir target    pc            instr   pc4       v  h  count
    vecs[0]  = mk(0, 0, 0, 32'h0,   32'h0,   32'h0,  32'h0,   0, 0, 32'd0);  // BOOT
    vecs[1]  = mk(0, 0, 0, 32'h0,   32'h4,   32'h11, 32'h4,   1, 0, 32'd1);
    vecs[2]  = mk(0, 0, 0, 32'h0,   32'h8,   32'h22, 32'h8,   1, 0, 32'd2);
    vecs[3]  = mk(1, 0, 0, 32'h0,   32'h8,   32'h22, 32'h8,   1, 0, 32'd2);
    vecs[4]  = mk(1, 0, 0, 32'h0,   32'h8,   32'h22, 32'h8,   1, 0, 32'd2);
    vecs[5]  = mk(1, 0, 0, 32'h0,   32'h8,   32'h22, 32'h8,   1, 0, 32'd2);
    vecs[6]  = mk(0, 0, 0, 32'h0,   32'hC,   32'h33, 32'hC,   1, 0, 32'd3);
    vecs[7]  = mk(0, 1, 0, 32'h0,   32'h10,  32'h0,  32'hC,   0, 0, 32'd3);
    vecs[8]  = mk(1, 1, 0, 32'h0,   32'h10,  32'h0,  32'hC,   0, 0, 32'd3);
    vecs[9]  = mk(1, 1, 1, 32'h103, 32'h100, 32'h0,  32'hC,   0, 0, 32'd3);
    vecs[10] = mk(0, 0, 0, 32'h0,   32'h104, 32'h11, 32'h104, 1, 0, 32'd4);
    vecs[11] = mk(0, 0, 1, 32'hC,   32'hC,   32'h0,  32'h104, 0, 0, 32'd4);
    vecs[12] = mk(0, 0, 0, 32'h0,   32'h10,  32'h44, 32'h10,  1, 0, 32'd5);
    vecs[13] = mk(0, 0, 0, 32'h0,   32'h10,  32'h0,  32'h10,  0, 1, 32'd5);  // halt word

    rst_n = 1'b0;
    drive0(0, 0, 0, 32'h0);
    bus1.Stall = 0; bus1.Flush = 0; bus1.Redirect = 0; bus1.RedirectTarget = 32'h0;

    tick();
    tick();
    chk_all0("reset", 32'h0, 32'h0, 32'h0, 0, 0, 32'd0);
    chk("reset.pc1", bus1.PCResult, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive0(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].target);
      tick();
      chk_all0($sformatf("vec%0d", i), vecs[i].pc, vecs[i].instr, vecs[i].p4,
               vecs[i].valid, vecs[i].halted, vecs[i].count);
    end

    // Halted ignores stall/flush for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      drive0(i[0], i[1], 0, 32'h0);
      tick();
      chk($sformatf("halt%0d.pc", i), bus0.PCResult, 32'h10);
      chk($sformatf("halt%0d.valid", i), {31'd0, bus0.IF_ID_Valid}, 32'd0);
      chk($sformatf("halt%0d.halted", i), {31'd0, bus0.Halted}, 32'd1);
      chk($sformatf("halt%0d.count", i), bus0.FetchCount, 32'd5);
    end

    drive0(1, 1, 1, 32'h0);
    tick();
    chk_all0("unhalt", 32'h0, 32'h0, 32'h10, 0, 0, 32'd5);
    drive0(0, 0, 0, 32'h0);
    tick();
    chk_all0("restart", 32'h4, 32'h11, 32'h4, 1, 0, 32'd6);

    // Asynchronous reset pulse between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_all0("areset", 32'h0, 32'h0, 32'h0, 0, 0, 32'd0);
    chk("areset.pc1", bus1.PCResult, 32'hFFFF_FFF8);
    chk("areset.count1", bus1.FetchCount, 32'd0);
    tick();
    rst_n = 1'b1;

    // Wrap-around from the high reset PC.
    tick();
    chk("wrap0.pc", bus1.PCResult, 32'hFFFF_FFF8);
    chk("wrap0.valid", {31'd0, bus1.IF_ID_Valid}, 32'd0);
    tick();
    chk("wrap1.pc", bus1.PCResult, 32'hFFFF_FFFC);
    chk("wrap1.instr", bus1.IF_ID_Instruction, 32'hAA);
    chk("wrap1.pc4", bus1.IF_ID_PCPlus4, 32'hFFFF_FFFC);
    tick();
    chk("wrap2.pc", bus1.PCResult, 32'h0);
    chk("wrap2.instr", bus1.IF_ID_Instruction, 32'hBB);
    chk("wrap2.pc4", bus1.IF_ID_PCPlus4, 32'h0);
    tick();
    chk("wrap3.pc", bus1.PCResult, 32'h4);
    chk("wrap3.instr", bus1.IF_ID_Instruction, 32'h11);
    chk("wrap3.count", bus1.FetchCount, 32'd3);
    chk("post.pc0", bus0.PCResult, 32'hC);
    chk("post.count0", bus0.FetchCount, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC loaded on reset.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, is the fetched word that halts fetch.
REQ-003 Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Instruction  input  32  word returned combinationally by instruction memory for PCResult.
REQ-006 Stall  input  1  hold PC and IF/ID register.
REQ-007 Flush  input  1  squash the IF/ID register contents.
REQ-008 Redirect  input  1  branch/jump taken; load RedirectTarget into PC.
REQ-009 RedirectTarget  input  32  new fetch address.
REQ-010 PCResult  output  32  current PC, driven to instruction memory.
REQ-011 IF_ID_Instruction  output  32  registered fetched instruction.
REQ-012 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-013 IF_ID_Valid  output  1  IF/ID holds a live instruction.
REQ-014 Halted  output  1  fetch stopped on HALT_WORD.
REQ-015 FetchCount  output  32  count of valid IF/ID loads.

Function
REQ-016 FSM states SHALL be BOOT, RUN and HALTED; Halted SHALL be 1 only in HALTED.
REQ-017 BOOT SHALL last exactly one cycle after Reset deasserts, perform no fetch, hold IF_ID_Valid=0, then go to RUN.
REQ-018 PCResult SHALL equal the PC register directly, with zero combinational logic between them.
REQ-019 In RUN with no Redirect, Flush or Stall, and Instruction != HALT_WORD, each edge SHALL load IF_ID_Instruction<=Instruction, IF_ID_PCPlus4<=PC+4, IF_ID_Valid<=1 and PC<=PC+4; fetch-to-IF/ID latency is one cycle.
REQ-020 PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 becomes 0.
REQ-021 Precedence SHALL be Redirect > Flush > Stall > halt detection > normal fetch.
REQ-022 Redirect, in any state but BOOT, SHALL load PC<={RedirectTarget[31:2],2'b00}, clear IF_ID_Valid, set IF_ID_Instruction to 0 (NOP) and move to RUN.
REQ-023 Flush without Redirect SHALL clear IF_ID_Valid and zero IF_ID_Instruction; PC SHALL hold if Stall=1 and otherwise advance by 4 with no IF/ID load.
REQ-024 Stall alone SHALL hold PC, all IF/ID outputs and FetchCount unchanged.
REQ-025 In RUN, when Instruction==HALT_WORD with no higher-precedence input, PC SHALL hold, IF_ID_Valid SHALL clear, IF_ID_Instruction SHALL become 0 and the state SHALL become HALTED.
REQ-026 HALTED SHALL hold PC and keep IF_ID_Valid=0, ignoring Stall and Flush; only Redirect or Reset leaves HALTED.
REQ-027 FetchCount SHALL increment on each edge that sets IF_ID_Valid<=1 and saturate at 32'hFFFF_FFFF.
REQ-028 Reset asserted mid-operation SHALL immediately force reset values regardless of FSM state or pending inputs.

Reset
REQ-029 On Reset=0: PC=RESET_PC, state=BOOT, IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0, Halted=0.
REQ-030 No output SHALL depend on Instruction while Reset=0.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, NOP_WORD (32'h0) and the default HALT_WORD.
REQ-032 The PC register with its next-PC mux SHALL be one sub-module, program_counter; the FSM, IF/ID register and counter stay in instruction_fetch_unit.
REQ-033 RTL SHALL be synthesizable, single clock domain, with no latches.

Verification
REQ-034 Reset release, memory words 0..3 = 0x11,0x22,0x33,0x44 -> first edge BOOT with Valid=0; following edges load IF_ID 0x11/PC+4=4, then 0x22/8, then 0x33/12; FetchCount=3.
REQ-035 Stall held for 3 cycles at PC=8 -> PCResult stays 8, IF_ID outputs and FetchCount frozen; release resumes with 0x33.
REQ-036 Redirect=1, RedirectTarget=0x103, together with Stall=1 and Flush=1 -> PC=0x100, IF_ID_Valid=0, IF_ID_Instruction=0.
REQ-037 HALT_WORD placed at address 0x10 -> Halted=1, PCResult stuck at 0x10, Valid=0 through 20 cycles; Redirect to 0 -> RUN, fetch restarts at 0.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> fetches at FFF8, FFFC, then 0 (wrap); Reset pulsed low mid-run -> all outputs return to reset values asynchronously.
